// File: rtl/icache_refill.sv
// icache_refill: memory-side line-fill engine for the instruction cache.
// Takes a level-held request and reads BLOCK_SIZE consecutive words from a
// fixed-latency word RAM. The words go back to the cache as single-cycle
// mem_val pulses, in ascending address order.
// Optional build macro ICACHE_REFILL_STATS_EN adds two saturating counters,
// refill_cnt and stall_cnt.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no burst; waits for mem_req and latches the line base address
// ISSUE | ram_en high; one word read accepted per granted cycle
// DRAIN | all reads accepted; waits for the last word to be returned
// DONE  | line delivered; waits for mem_req to fall before a new burst
module icache_refill #(
    parameter int BLOCK_SIZE  = 8,
    parameter int RAM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic [31:0] mem_addr,
    output logic        mem_val,
    output logic [31:0] mem_data,
    output logic        ram_en,
    output logic [31:0] ram_addr,
    input  logic        ram_gnt,
    input  logic [31:0] ram_rdata
`ifdef ICACHE_REFILL_STATS_EN
    ,
    output logic [31:0] refill_cnt,
    output logic [31:0] stall_cnt
`endif
);

    localparam int OFF_W = $clog2(BLOCK_SIZE * 4);
    localparam int CNT_W = $clog2(BLOCK_SIZE) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_SIZE - 1);
    localparam logic [CNT_W-1:0] BLK_CNT  = CNT_W'(BLOCK_SIZE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            base_q, base_d;
    logic [CNT_W-1:0]       issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]       ret_cnt_q, ret_cnt_d;
    logic [RAM_LATENCY-1:0] vld_q, vld_d;
    logic                   mem_val_q, mem_val_d;
    logic [31:0]            mem_data_q, mem_data_d;

    logic                   rd_acc;
    logic                   rd_ret;
    logic [31:0]            word_off;
    logic                   unused_addr_bits;

    // The offset bits of the miss address are irrelevant: the line base is used.
    assign unused_addr_bits = ^mem_addr[OFF_W-1:0];

    // RAM request side is a pure decode of the state and issue counter, so
    // ram_addr stays stable across grant stalls.
    assign word_off = {{(32 - CNT_W - 2){1'b0}}, issue_cnt_q, 2'b00};
    assign ram_en   = (state_q == ISSUE);
    assign ram_addr = ram_en ? (base_q + word_off) : 32'd0;
    assign rd_acc   = ram_en & ram_gnt;
    assign rd_ret   = vld_q[RAM_LATENCY-1];

    assign mem_val  = mem_val_q;
    assign mem_data = mem_data_q;

    // Next-state logic for the burst FSM and its counters.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;

        if (rd_ret) begin
            ret_cnt_d = ret_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    base_d      = {mem_addr[31:OFF_W], {OFF_W{1'b0}}};
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (rd_acc) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    if (issue_cnt_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // ret_cnt reaches BLOCK_SIZE on the same edge that raises the
                // final mem_val, so the last word is already out here.
                if (ret_cnt_q == BLK_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!mem_req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Valid shift pipeline marks cycles in which ram_rdata carries a word.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = rd_acc;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    // Return register: capture the RAM word and pulse mem_val for one cycle.
    always_comb begin
        mem_val_d  = rd_ret;
        mem_data_d = rd_ret ? ram_rdata : mem_data_q;
    end

    // State and datapath registers; reset also discards in-flight returns.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            vld_q       <= '0;
            mem_val_q   <= 1'b0;
            mem_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            vld_q       <= vld_d;
            mem_val_q   <= mem_val_d;
            mem_data_q  <= mem_data_d;
        end
    end

`ifdef ICACHE_REFILL_STATS_EN
    logic [31:0] refill_cnt_q, refill_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating counters: completed refills and grant-stalled issue cycles.
    always_comb begin
        refill_cnt_d = refill_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if ((state_q != DONE) && (state_d == DONE) && (refill_cnt_q != 32'hFFFF_FFFF)) begin
            refill_cnt_d = refill_cnt_q + 32'd1;
        end
        if ((state_q == ISSUE) && !ram_gnt && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refill_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            refill_cnt_q <= refill_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign refill_cnt = refill_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: two instances (RAM_LATENCY 1 and 3) share
// request/grant stimulus; each has its own RAM model returning word = address.
module tb_icache_refill;

    localparam int BLK = 8;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        ram_gnt;

    logic        mem_val1, mem_val3;
    logic [31:0] mem_data1, mem_data3;
    logic        ram_en1, ram_en3;
    logic [31:0] ram_addr1, ram_addr3;
    logic [31:0] ram_rdata1, ram_rdata3;
`ifdef ICACHE_REFILL_STATS_EN
    logic [31:0] refill_cnt1, refill_cnt3, stall_cnt1, stall_cnt3;
`endif

    int n_chk;
    int n_err;
    int exp_refill;
    int exp_stall;

    icache_refill #(.BLOCK_SIZE(BLK), .RAM_LATENCY(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_val   (mem_val1),
        .mem_data  (mem_data1),
        .ram_en    (ram_en1),
        .ram_addr  (ram_addr1),
        .ram_gnt   (ram_gnt),
        .ram_rdata (ram_rdata1)
`ifdef ICACHE_REFILL_STATS_EN
        ,
        .refill_cnt(refill_cnt1),
        .stall_cnt (stall_cnt1)
`endif
    );

    icache_refill #(.BLOCK_SIZE(BLK), .RAM_LATENCY(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_val   (mem_val3),
        .mem_data  (mem_data3),
        .ram_en    (ram_en3),
        .ram_addr  (ram_addr3),
        .ram_gnt   (ram_gnt),
        .ram_rdata (ram_rdata3)
`ifdef ICACHE_REFILL_STATS_EN
        ,
        .refill_cnt(refill_cnt3),
        .stall_cnt (stall_cnt3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: word content equals its byte address
    logic [31:0] pipe1 [1];
    logic [31:0] pipe3 [3];
    always @(posedge clk) begin
        pipe1[0] <= (ram_en1 && ram_gnt) ? ram_addr1 : 32'hDEAD_BEEF;
        pipe3[0] <= (ram_en3 && ram_gnt) ? ram_addr3 : 32'hDEAD_BEEF;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign ram_rdata1 = pipe1[0];
    assign ram_rdata3 = pipe3[2];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_stats();
`ifdef ICACHE_REFILL_STATS_EN
        chk("refill_cnt1", refill_cnt1, 32'(exp_refill));
        chk("refill_cnt3", refill_cnt3, 32'(exp_refill));
        chk("stall_cnt1", stall_cnt1, 32'(exp_stall));
        chk("stall_cnt3", stall_cnt3, 32'(exp_stall));
`endif
    endtask

    // Runs ncyc cycles of one fill starting at a negedge (cycle 0 = request
    // cycle). Grant is low in cycles st_lo..st_hi; mem_req is high in cycles
    // before req_drop. Checks both instances every cycle against a small
    // acceptance-time model and reports observed first/last/count of mem_val.
    task automatic fill(input logic [31:0] addr, input int st_lo, input int st_hi,
                        input int req_drop, input int ncyc,
                        output int first1, output int last1, output int cnt1,
                        output int first3, output int last3, output int cnt3);
        logic [31:0] base;
        int          acc [BLK];
        int          ei, rk1, rk3;
        logic        en_exp, v1_exp, v3_exp;
        base = addr & 32'hFFFF_FFE0;
        ei = 0; rk1 = 0; rk3 = 0;
        first1 = -1; last1 = -1; cnt1 = 0;
        first3 = -1; last3 = -1; cnt3 = 0;
        for (int c = 0; c < ncyc; c++) begin
            mem_req  = (c < req_drop);
            mem_addr = addr;
            ram_gnt  = !((c >= st_lo) && (c <= st_hi));
            #1;
            en_exp = (c >= 1) && (ei < BLK);
            chk("ram_en1", 32'(ram_en1), 32'(en_exp));
            chk("ram_en3", 32'(ram_en3), 32'(en_exp));
            if (en_exp) begin
                chk("ram_addr1", ram_addr1, base + 32'(4 * ei));
                chk("ram_addr3", ram_addr3, base + 32'(4 * ei));
            end
            v1_exp = (rk1 < ei) && (acc[rk1] + 2 == c);
            v3_exp = (rk3 < ei) && (acc[rk3] + 4 == c);
            chk("mem_val1", 32'(mem_val1), 32'(v1_exp));
            chk("mem_val3", 32'(mem_val3), 32'(v3_exp));
            if (v1_exp) begin
                chk("mem_data1", mem_data1, base + 32'(4 * rk1));
                rk1++;
            end
            if (v3_exp) begin
                chk("mem_data3", mem_data3, base + 32'(4 * rk3));
                rk3++;
            end
            if (mem_val1) begin
                if (first1 < 0) first1 = c;
                last1 = c;
                cnt1++;
            end
            if (mem_val3) begin
                if (first3 < 0) first3 = c;
                last3 = c;
                cnt3++;
            end
            if (en_exp && !ram_gnt) exp_stall++;
            if (en_exp && ram_gnt) begin
                acc[ei] = c;
                ei++;
            end
            @(negedge clk);
        end
        exp_refill++;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_val1"}, 32'(mem_val1), 32'd0);
        chk({tag, "_val3"}, 32'(mem_val3), 32'd0);
        chk({tag, "_data1"}, mem_data1, 32'd0);
        chk({tag, "_data3"}, mem_data3, 32'd0);
        chk({tag, "_en1"}, 32'(ram_en1), 32'd0);
        chk({tag, "_en3"}, 32'(ram_en3), 32'd0);
        chk({tag, "_addr1"}, ram_addr1, 32'd0);
        chk({tag, "_addr3"}, ram_addr3, 32'd0);
`ifdef ICACHE_REFILL_STATS_EN
        chk({tag, "_refill1"}, refill_cnt1, 32'd0);
        chk({tag, "_stall1"}, stall_cnt1, 32'd0);
`endif
    endtask

    initial begin
        int f1, l1, c1, f3, l3, c3;
        n_chk = 0;
        n_err = 0;
        exp_refill = 0;
        exp_stall  = 0;
        reset    = 1'b0;
        mem_req  = 1'b0;
        mem_addr = 32'd0;
        ram_gnt  = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        chk_outputs_zero("rst");
        reset = 1'b1;
        @(negedge clk);

        // basic fill, request held two cycles past the last word
        fill(32'h0040_0024, -1, -1, 13, 15, f1, l1, c1, f3, l3, c3);
        chk("basic_first1", 32'(f1), 32'd3);
        chk("basic_last1", 32'(l1), 32'd10);
        chk("basic_cnt1", 32'(c1), 32'd8);
        chk("basic_first3", 32'(f3), 32'd5);
        chk("basic_last3", 32'(l3), 32'd12);
        chk("basic_cnt3", 32'(c3), 32'd8);

        // re-request right after IDLE
        fill(32'h0000_0100, -1, -1, 13, 15, f1, l1, c1, f3, l3, c3);
        chk("rereq_first1", 32'(f1), 32'd3);
        chk("rereq_cnt1", 32'(c1), 32'd8);
        chk_stats();

        // grant stalls in cycles 3..5
        fill(32'h0040_0024, 3, 5, 16, 18, f1, l1, c1, f3, l3, c3);
        chk("stall_last1", 32'(l1), 32'd13);
        chk("stall_cnt1", 32'(c1), 32'd8);
        chk("stall_last3", 32'(l3), 32'd15);
`ifdef ICACHE_REFILL_STATS_EN
        chk("stall_stat1", stall_cnt1, 32'd3);
`endif
        chk_stats();

        // back-to-back fills at 0x0 and 0x20
        fill(32'h0000_0000, -1, -1, 13, 15, f1, l1, c1, f3, l3, c3);
        chk("sweep0_first3", 32'(f3), 32'd5);
        chk("sweep0_cnt3", 32'(c3), 32'd8);
        fill(32'h0000_0020, -1, -1, 13, 15, f1, l1, c1, f3, l3, c3);
        chk("sweep1_first3", 32'(f3), 32'd5);
        chk("sweep1_cnt3", 32'(c3), 32'd8);
        chk_stats();

        // mem_req dropped in cycle 4; line still delivered, then straight to IDLE
        fill(32'h0000_0040, -1, -1, 4, 11, f1, l1, c1, f3, l3, c3);
        chk("drop_cnt1", 32'(c1), 32'd8);
        chk("drop_last1", 32'(l1), 32'd10);
        #1;
        chk("drop_st1_c11", 32'(dut1.state_q), 32'd3);
        chk("drop_val3_c11", 32'(mem_val3), 32'd1);
        chk("drop_data3_c11", mem_data3, 32'h0000_0058);
        @(negedge clk);
        #1;
        chk("drop_st1_c12", 32'(dut1.state_q), 32'd0);
        chk("drop_st3_c12", 32'(dut3.state_q), 32'd2);
        chk("drop_val3_c12", 32'(mem_val3), 32'd1);
        chk("drop_data3_c12", mem_data3, 32'h0000_005C);
        @(negedge clk);
        #1;
        chk("drop_st3_c13", 32'(dut3.state_q), 32'd3);
        chk("drop_val3_c13", 32'(mem_val3), 32'd0);
        @(negedge clk);
        #1;
        chk("drop_st3_c14", 32'(dut3.state_q), 32'd0);
        @(negedge clk);
        chk_stats();

        // reset asserted in cycle 5 of a fill
        fill(32'h0040_0000, -1, -1, 100, 5, f1, l1, c1, f3, l3, c3);
        chk("rstmid_cnt1", 32'(c1), 32'd2);
        reset   = 1'b0;
        mem_req = 1'b0;
        #1;
        chk_outputs_zero("rstmid");
        exp_refill = 0;
        exp_stall  = 0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("post_rst_val1", 32'(mem_val1), 32'd0);
            chk("post_rst_val3", 32'(mem_val3), 32'd0);
            chk("post_rst_en1", 32'(ram_en1), 32'd0);
            @(negedge clk);
        end
        chk_stats();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/icache_refill.md
# icache_refill

Memory-side refill engine for the instruction cache. It accepts a level-held line-fill request (`mem_req`/`mem_addr`) and reads `BLOCK_SIZE` consecutive words from a pipelined, fixed-latency word RAM. It returns them to the cache as single-cycle `mem_val` pulses in ascending address order. It sits directly between the icache and the shared instruction memory port, which is arbitrated via `ram_gnt`.

## Interface
- `BLOCK_SIZE`, 8: words per line; power of two, 2..16.
- `RAM_LATENCY`, 1: cycles from an accepted RAM read to `ram_rdata` valid; 1..4.

- `clk` in 1: clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `mem_req` in 1: line-fill request from the icache, held high until the cache has consumed the line.
- `mem_addr` in 32: byte address of the miss. Only bits [31:log2(BLOCK_SIZE*4)] are used.
- `mem_val` out 1: one-cycle pulse per returned word.
- `mem_data` out 32: returned word, valid when `mem_val` is high.
- `ram_en` out 1: read request to the RAM.
- `ram_addr` out 32: word-aligned byte address of the read.
- `ram_gnt` in 1: the read is accepted in any cycle with `ram_en & ram_gnt`.
- `ram_rdata` in 32: read data, valid exactly `RAM_LATENCY` cycles after acceptance.

## Operation
- **Reset values:** state IDLE, `mem_val`=0, `mem_data`=0, `ram_en`=0, `ram_addr`=0, all counters 0, return-tracking pipeline cleared.
- **IDLE**
  - `ram_en`=0.
  - If `mem_req`=1: latch `base` = `mem_addr` with the low log2(BLOCK_SIZE*4) bits cleared, clear `issue_cnt` and `ret_cnt`, go to ISSUE.
- **ISSUE**
  - `ram_en`=1, `ram_addr` = `base` + 4*`issue_cnt`.
  - On each accepted read: `issue_cnt`++.
  - When the read with `issue_cnt`=BLOCK_SIZE-1 is accepted: go to DRAIN. `ram_en` drops the next cycle.
- **Return tracking**
  - A RAM_LATENCY-deep valid shift pipeline, fed by `ram_en & ram_gnt`, marks the cycles in which `ram_rdata` is valid.
  - In each such cycle, the next edge registers `mem_data`<=`ram_rdata`, `mem_val`<=1, `ret_cnt`++.
  - Otherwise `mem_val`<=0 and `mem_data` holds its value.
- **DRAIN:** when `ret_cnt`=BLOCK_SIZE and `mem_val` has been issued for the last word, go to DONE.
- **DONE:** wait for `mem_req`=0, then go to IDLE.
  - While `mem_req` stays high in DONE, no new burst is started. This holds because the cache keeps `mem_req` high for up to 2 cycles after the last `mem_val`.
- **`mem_req` drops mid-burst (ISSUE/DRAIN):** ignored. The burst completes and all words are returned. DONE then exits immediately.
- **Counter widths:** `issue_cnt`/`ret_cnt` are log2(BLOCK_SIZE)+1 bits and never wrap. Address arithmetic is 32-bit and stays within one aligned line.
- **Reset mid-burst:** all state is cleared asynchronously. RAM returns still in flight are discarded; no `mem_val` follows reset release unless a new burst was issued.

## Timing
- With `ram_gnt` constantly high and `mem_req` first high in cycle 0:
  - Reads are accepted in cycles 1..BLOCK_SIZE.
  - Word k appears with `mem_val` in cycle k+2+RAM_LATENCY.
  - The first word arrives in cycle 2+RAM_LATENCY.
- Each cycle of `ram_gnt`=0 in ISSUE delays all later words by one cycle. `ram_addr` is stable while stalled.
- `mem_val` pulses are back-to-back when there are no stalls. They are never merged and never reordered.
- Minimum gap between bursts: one IDLE cycle after `mem_req` falls.

## Configuration
- `ICACHE_REFILL_STATS_EN`
  - Defined: adds two 32-bit outputs, both saturating at 0xFFFFFFFF and reset to 0.
    - `refill_cnt`: increments on each entry to DONE.
    - `stall_cnt`: increments on each ISSUE cycle with `ram_gnt`=0.
  - Undefined: these ports and their registers are absent; behaviour is otherwise identical.

## Test plan
- **Basic fill:** BLOCK_SIZE=8, RAM_LATENCY=1, `ram_gnt`=1, RAM word = address; `mem_req`=1 with `mem_addr`=0x00400024 -> `ram_addr` 0x00400020..0x0040003C in cycles 1..8; `mem_val` in cycles 3..10 with `mem_data` 0x00400020..0x0040003C.
- **Grant stalls:** `ram_gnt`=0 for cycles 3..5 during the same fill -> `ram_addr` holds 0x00400028 through cycles 3..5; 8 words arrive in order, last `mem_val` in cycle 13; `stall_cnt`=3 when the macro is defined.
- **Held request:** `mem_req` held high for 2 cycles after the last `mem_val` -> no `ram_en` in those cycles; lowering `mem_req` then raising it again with 0x00000100 starts a new burst at 0x00000100.
- **Latency sweep:** RAM_LATENCY=3, back-to-back fills at 0x0 and 0x20 -> first `mem_val` in cycle 5 of each burst; 16 words total, correct order; `refill_cnt`=2.
- **Reset mid-burst:** assert `reset` (low) in cycle 5 of a fill -> all outputs 0 immediately; after release with `mem_req`=0, no `mem_val` ever appears.
- **Early request drop:** `mem_req` dropped in cycle 4 -> all 8 words are still delivered, and the block returns to IDLE one cycle after DONE.
